// File: rtl/avalon_ahb_pkg.sv
// Shared constants and types for the Avalon-MM to AHB-Lite bridge.
// HTRANS/HSIZE/HBURST encodings, Avalon response codes, FSM states.
package avalon_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RDRESP
    } state_e;

    typedef struct packed {
        logic [2:0] hsize;
        logic [1:0] offset;
        logic       legal;
    } be_dec_t;

endpackage

// File: rtl/avalon_ahb_bridge_if.sv
// Bundle of the Avalon-MM slave port and the AHB-Lite master port.
// slave = bridge view, master = Avalon host plus AHB slave view.
interface avalon_ahb_bridge_if #(
    parameter int ADDR_WIDTH = 32
);

    logic [ADDR_WIDTH-1:0] avs_address;
    logic                  avs_read;
    logic                  avs_write;
    logic [3:0]            avs_byteenable;
    logic [31:0]           avs_writedata;
    logic                  avs_waitrequest;
    logic [31:0]           avs_readdata;
    logic                  avs_readdatavalid;
    logic [1:0]            avs_response;

    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [31:0]           HWDATA;
    logic [31:0]           HRDATA;
    logic                  HREADY;
    logic                  HRESP;

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_byteenable,
        input  avs_writedata,
        output avs_waitrequest,
        output avs_readdata,
        output avs_readdatavalid,
        output avs_response,
        output HADDR,
        output HTRANS,
        output HWRITE,
        output HSIZE,
        output HBURST,
        output HPROT,
        output HWDATA,
        input  HRDATA,
        input  HREADY,
        input  HRESP
    );

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_byteenable,
        output avs_writedata,
        input  avs_waitrequest,
        input  avs_readdata,
        input  avs_readdatavalid,
        input  avs_response,
        input  HADDR,
        input  HTRANS,
        input  HWRITE,
        input  HSIZE,
        input  HBURST,
        input  HPROT,
        input  HWDATA,
        output HRDATA,
        output HREADY,
        output HRESP
    );

endinterface

// File: rtl/avalon_ahb_be_decode.sv
// Byteenable to AHB size/low-address decode.
// Only naturally aligned byte, half and word lane patterns are legal.
module avalon_ahb_be_decode
    import avalon_ahb_pkg::*;
(
    input  logic [3:0] be_i,
    output be_dec_t    dec_o
);

    // Map each legal lane pattern to its transfer size and byte offset
    always_comb begin
        dec_o = '{hsize: HSIZE_WORD, offset: 2'b00, legal: 1'b0};
        unique case (be_i)
            4'b1111: dec_o = '{hsize: HSIZE_WORD, offset: 2'd0, legal: 1'b1};
            4'b0011: dec_o = '{hsize: HSIZE_HALF, offset: 2'd0, legal: 1'b1};
            4'b1100: dec_o = '{hsize: HSIZE_HALF, offset: 2'd2, legal: 1'b1};
            4'b0001: dec_o = '{hsize: HSIZE_BYTE, offset: 2'd0, legal: 1'b1};
            4'b0010: dec_o = '{hsize: HSIZE_BYTE, offset: 2'd1, legal: 1'b1};
            4'b0100: dec_o = '{hsize: HSIZE_BYTE, offset: 2'd2, legal: 1'b1};
            4'b1000: dec_o = '{hsize: HSIZE_BYTE, offset: 2'd3, legal: 1'b1};
            default: dec_o = '{hsize: HSIZE_WORD, offset: 2'd0, legal: 1'b0};
        endcase
    end

endmodule

// File: rtl/avalon_ahb_bridge.sv
// Avalon-MM slave to AHB-Lite master bridge, one outstanding transfer.
// Each accepted command becomes a single NONSEQ transfer on AHB.
module avalon_ahb_bridge
    import avalon_ahb_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
    input  logic               clk,
    input  logic               rst,
    avalon_ahb_bridge_if.slave bus,
    output logic               wr_err,
    input  logic               wr_err_clr
);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] haddr_q;
    logic [1:0]            htrans_q;
    logic                  hwrite_q;
    logic [2:0]            hsize_q;
    logic [31:0]           hwdata_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic                  rdv_q;
    logic [1:0]            resp_q;
    logic                  err_q;
    logic                  wr_err_q;
    logic                  wr_err_d;
    logic                  wr_err_set;
    logic                  cmd;
    logic                  accept;
    be_dec_t               dec;
    logic                  unused_addr;

    avalon_ahb_be_decode u_be_decode (
        .be_i  (bus.avs_byteenable),
        .dec_o (dec)
    );

    assign cmd    = bus.avs_read | bus.avs_write;
    assign accept = cmd & (state_q == ST_IDLE);

    // Address low bits come from byteenable, not from the master
    assign unused_addr = ^bus.avs_address[1:0];

    // Sticky write error sources: illegal lanes or an AHB ERROR on a write
    assign wr_err_set =
        (accept & bus.avs_write & ~dec.legal) |
        ((state_q == ST_DATA) & bus.HREADY & hwrite_q &
         (err_q | bus.HRESP));

    // Clear request loses against a simultaneous new error
    always_comb begin
        wr_err_d = wr_err_q;
        if (wr_err_clr) begin
            wr_err_d = 1'b0;
        end
        if (wr_err_set) begin
            wr_err_d = 1'b1;
        end
    end

    // Sticky write error register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_err_d;
        end
    end

    // Transfer sequencer with registered AHB and Avalon outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            haddr_q  <= '0;
            htrans_q <= HTRANS_IDLE;
            hwrite_q <= 1'b0;
            hsize_q  <= HSIZE_WORD;
            hwdata_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rdv_q    <= 1'b0;
            resp_q   <= RESP_OKAY;
            err_q    <= 1'b0;
        end else begin
            rdv_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd) begin
                        if (dec.legal) begin
                            state_q  <= ST_ADDR;
                            htrans_q <= HTRANS_NONSEQ;
                            haddr_q  <= {bus.avs_address[ADDR_WIDTH-1:2],
                                         dec.offset};
                            hsize_q  <= dec.hsize;
                            hwrite_q <= bus.avs_write;
                            wdata_q  <= bus.avs_writedata;
                            err_q    <= 1'b0;
                        end else if (!bus.avs_write) begin
                            state_q <= ST_RDRESP;
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (bus.HREADY) begin
                        state_q  <= ST_DATA;
                        htrans_q <= HTRANS_IDLE;
                        if (hwrite_q) begin
                            hwdata_q <= wdata_q;
                        end
                    end
                end
                ST_DATA: begin
                    if (bus.HRESP) begin
                        err_q <= 1'b1;
                    end
                    if (bus.HREADY) begin
                        if (hwrite_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            rdata_q <= bus.HRDATA;
                            state_q <= ST_RDRESP;
                        end
                    end
                end
                ST_RDRESP: begin
                    rdv_q   <= 1'b1;
                    resp_q  <= err_q ? RESP_SLVERR : RESP_OKAY;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.avs_waitrequest   = (state_q != ST_IDLE);
    assign bus.avs_readdata      = rdata_q;
    assign bus.avs_readdatavalid = rdv_q;
    assign bus.avs_response      = resp_q;

    assign bus.HADDR  = haddr_q;
    assign bus.HTRANS = htrans_q;
    assign bus.HWRITE = hwrite_q;
    assign bus.HSIZE  = hsize_q;
    assign bus.HBURST = HBURST_SINGLE;
    assign bus.HPROT  = HPROT_VAL;
    assign bus.HWDATA = hwdata_q;

    assign wr_err = wr_err_q;

endmodule

// File: tb/tb_avalon_ahb_bridge.sv
// Scoreboard bench for the Avalon-MM to AHB-Lite bridge.
// Directed commands push expectations; monitors pop and compare.
module tb_avalon_ahb_bridge;
    import avalon_ahb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_err;
    logic wr_err_clr = 1'b0;

    avalon_ahb_bridge_if #(.ADDR_WIDTH(32)) bus ();

    avalon_ahb_bridge #(
        .ADDR_WIDTH (32),
        .HPROT_VAL  (4'b0011)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .wr_err     (wr_err),
        .wr_err_clr (wr_err_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        int          due;
    } rd_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
        logic [31:0] wdata;
    } ahb_exp_t;

    rd_exp_t  rd_q[$];
    ahb_exp_t ahb_q[$];
    int       nonseq_cnt = 0;

    int          slv_wait = 0;
    logic        slv_err = 1'b0;
    logic [31:0] slv_rdata = '0;

    // AHB slave model plus address/data phase checker
    initial begin
        bit          dp;
        bit          err1;
        bit          dwr;
        int          wcnt;
        logic [31:0] dwdata;
        ahb_exp_t    e;
        dp = 0; err1 = 0; dwr = 0; wcnt = 0; dwdata = '0;
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                dp = 0; err1 = 0; wcnt = 0;
                bus.HREADY = 1'b1;
                bus.HRESP  = 1'b0;
            end else if (dp) begin
                if (dwr) chk("hwdata", bus.HWDATA, dwdata);
                chk("htrans_dphase", bus.HTRANS, HTRANS_IDLE);
                if (slv_err && !err1) begin
                    bus.HREADY = 1'b0;
                    bus.HRESP  = 1'b1;
                    err1 = 1;
                end else begin
                    bus.HREADY = 1'b1;
                    bus.HRESP  = slv_err;
                    bus.HRDATA = slv_rdata;
                    dp = 0;
                    err1 = 0;
                end
            end else if (bus.HTRANS == HTRANS_NONSEQ) begin
                if (ahb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_nonseq haddr=0x%08h", bus.HADDR);
                    bus.HREADY = 1'b1;
                    dp = 1;
                    dwr = 0;
                end else begin
                    e = ahb_q[0];
                    chk("haddr", bus.HADDR, e.addr);
                    if (wcnt < slv_wait) begin
                        bus.HREADY = 1'b0;
                        wcnt++;
                    end else begin
                        chk("hsize", {29'd0, bus.HSIZE}, {29'd0, e.size});
                        chk("hwrite", {31'd0, bus.HWRITE}, {31'd0, e.wr});
                        chk("hburst", {29'd0, bus.HBURST}, 32'd0);
                        chk("hprot", {28'd0, bus.HPROT}, 32'd3);
                        void'(ahb_q.pop_front());
                        nonseq_cnt++;
                        bus.HREADY = 1'b1;
                        bus.HRESP  = 1'b0;
                        wcnt = 0;
                        dp = 1;
                        dwr = e.wr;
                        dwdata = e.wdata;
                    end
                end
            end else begin
                bus.HREADY = 1'b1;
                bus.HRESP  = 1'b0;
            end
        end
    end

    // Avalon read response monitor
    always @(negedge clk) begin
        rd_exp_t r;
        if (!rst && bus.avs_readdatavalid) begin
            if (rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_readdatavalid cycle=%0d", cyc);
            end else begin
                r = rd_q.pop_front();
                chk("readdata", bus.avs_readdata, r.data);
                chk("response", {30'd0, bus.avs_response}, {30'd0, r.resp});
                chk("rdv_latency", cyc, r.due);
            end
        end
    end

    task automatic rd(logic [31:0] addr, logic [3:0] be,
                      logic [31:0] haddr, logic [2:0] hsize, logic legal,
                      logic [31:0] data, logic [1:0] resp, int lat);
        rd_exp_t  r;
        ahb_exp_t a;
        @(negedge clk);
        slv_rdata = data;
        if (legal) begin
            a = '{addr: haddr, size: hsize, wr: 1'b0, wdata: '0};
            ahb_q.push_back(a);
        end
        r = '{data: legal ? data : 32'd0, resp: resp, due: cyc + 1 + lat};
        rd_q.push_back(r);
        bus.avs_address    = addr;
        bus.avs_byteenable = be;
        bus.avs_read       = 1'b1;
        @(negedge clk);
        bus.avs_read = 1'b0;
    endtask

    task automatic wr(logic [31:0] addr, logic [3:0] be, logic [31:0] wd,
                      logic [31:0] haddr, logic [2:0] hsize, logic legal,
                      output int wcycles);
        ahb_exp_t a;
        int n;
        @(negedge clk);
        if (legal) begin
            a = '{addr: haddr, size: hsize, wr: 1'b1, wdata: wd};
            ahb_q.push_back(a);
        end
        bus.avs_address    = addr;
        bus.avs_byteenable = be;
        bus.avs_writedata  = wd;
        bus.avs_write      = 1'b1;
        @(negedge clk);
        bus.avs_write = 1'b0;
        n = 0;
        while (bus.avs_waitrequest && n < 20) begin
            n++;
            @(negedge clk);
        end
        wcycles = n;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((rd_q.size() != 0 || ahb_q.size() != 0 ||
                bus.avs_waitrequest) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL wait_done_timeout rd_q=%0d ahb_q=%0d",
                     rd_q.size(), ahb_q.size());
            rd_q.delete();
            ahb_q.delete();
        end
    endtask

    task automatic check_reset();
        chk("rst_waitrequest", {31'd0, bus.avs_waitrequest}, 32'd0);
        chk("rst_rdv", {31'd0, bus.avs_readdatavalid}, 32'd0);
        chk("rst_readdata", bus.avs_readdata, 32'd0);
        chk("rst_response", {30'd0, bus.avs_response}, 32'd0);
        chk("rst_htrans", {30'd0, bus.HTRANS}, 32'd0);
        chk("rst_hwrite", {31'd0, bus.HWRITE}, 32'd0);
        chk("rst_haddr", bus.HADDR, 32'd0);
        chk("rst_hsize", {29'd0, bus.HSIZE}, 32'd2);
        chk("rst_hwdata", bus.HWDATA, 32'd0);
        chk("rst_wr_err", {31'd0, wr_err}, 32'd0);
        chk("rst_hburst", {29'd0, bus.HBURST}, 32'd0);
        chk("rst_hprot", {28'd0, bus.HPROT}, 32'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int n;
        int ns0;
        ahb_exp_t a;
        bus.avs_address    = '0;
        bus.avs_read       = 1'b0;
        bus.avs_write      = 1'b0;
        bus.avs_byteenable = '0;
        bus.avs_writedata  = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset();
        rst = 1'b0;

        rd(32'h100, 4'b1111, 32'h100, HSIZE_WORD, 1, 32'hDEADBEEF,
           RESP_OKAY, 3);
        wait_done();
        @(negedge clk);
        chk("idle_waitrequest", {31'd0, bus.avs_waitrequest}, 32'd0);

        wr(32'h204, 4'b0100, 32'h00AB0000, 32'h206, HSIZE_BYTE, 1, n);
        chk("write_wait_cycles", n, 2);
        wait_done();
        chk("wr_err_ok", {31'd0, wr_err}, 32'd0);

        wr(32'h30C, 4'b1100, 32'h12340000, 32'h30E, HSIZE_HALF, 1, n);
        chk("write_half_wait", n, 2);
        wait_done();
        rd(32'h40, 4'b1000, 32'h43, HSIZE_BYTE, 1, 32'h11000000,
           RESP_OKAY, 3);
        wait_done();
        rd(32'h50, 4'b0011, 32'h50, HSIZE_HALF, 1, 32'h0000BEEF,
           RESP_OKAY, 3);
        wait_done();

        ns0 = nonseq_cnt;
        slv_wait = 3;
        rd(32'h500, 4'b1111, 32'h500, HSIZE_WORD, 1, 32'hCAFEF00D,
           RESP_OKAY, 6);
        wait_done();
        slv_wait = 0;
        chk("nonseq_once", nonseq_cnt - ns0, 1);

        slv_err = 1'b1;
        rd(32'h600, 4'b1111, 32'h600, HSIZE_WORD, 1, 32'hBAD0BAD0,
           RESP_SLVERR, 4);
        wait_done();
        wr(32'h604, 4'b1111, 32'h55AA55AA, 32'h604, HSIZE_WORD, 1, n);
        chk("write_err_wait", n, 3);
        wait_done();
        slv_err = 1'b0;
        chk("wr_err_set", {31'd0, wr_err}, 32'd1);
        repeat (3) @(negedge clk);
        chk("wr_err_hold", {31'd0, wr_err}, 32'd1);
        wr_err_clr = 1'b1;
        @(negedge clk);
        wr_err_clr = 1'b0;
        chk("wr_err_clr", {31'd0, wr_err}, 32'd0);

        ns0 = nonseq_cnt;
        rd(32'h700, 4'b0110, 32'h0, HSIZE_WORD, 0, 32'h12345678,
           RESP_SLVERR, 1);
        wait_done();
        chk("illegal_rd_no_ahb", nonseq_cnt - ns0, 0);
        wr(32'h704, 4'b0000, 32'h1, 32'h0, HSIZE_WORD, 0, n);
        chk("illegal_wr_wait", n, 0);
        chk("illegal_wr_err", {31'd0, wr_err}, 32'd1);
        chk("illegal_wr_no_ahb", nonseq_cnt - ns0, 0);
        wr_err_clr = 1'b1;
        @(negedge clk);
        wr_err_clr = 1'b0;
        chk("wr_err_clr2", {31'd0, wr_err}, 32'd0);

        @(negedge clk);
        bus.avs_address    = 32'h708;
        bus.avs_byteenable = 4'b0101;
        bus.avs_write      = 1'b1;
        wr_err_clr         = 1'b1;
        @(negedge clk);
        bus.avs_write = 1'b0;
        wr_err_clr    = 1'b0;
        chk("wr_err_set_wins", {31'd0, wr_err}, 32'd1);
        wr_err_clr = 1'b1;
        @(negedge clk);
        wr_err_clr = 1'b0;

        ns0 = nonseq_cnt;
        @(negedge clk);
        a = '{addr: 32'h800, size: HSIZE_WORD, wr: 1'b1,
              wdata: 32'h0F0F0F0F};
        ahb_q.push_back(a);
        bus.avs_address    = 32'h800;
        bus.avs_byteenable = 4'b1111;
        bus.avs_writedata  = 32'h0F0F0F0F;
        bus.avs_read       = 1'b1;
        bus.avs_write      = 1'b1;
        @(negedge clk);
        bus.avs_read  = 1'b0;
        bus.avs_write = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        chk("rw_write_wins", nonseq_cnt - ns0, 1);

        @(negedge clk);
        a = '{addr: 32'h900, size: HSIZE_WORD, wr: 1'b0, wdata: '0};
        ahb_q.push_back(a);
        bus.avs_address    = 32'h900;
        bus.avs_byteenable = 4'b1111;
        bus.avs_read       = 1'b1;
        @(negedge clk);
        bus.avs_read = 1'b0;
        @(negedge clk);
        chk("mid_xfer_busy", {31'd0, bus.avs_waitrequest}, 32'd1);
        rst = 1'b1;
        #1;
        check_reset();
        ahb_q.delete();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        rd(32'h104, 4'b1111, 32'h104, HSIZE_WORD, 1, 32'h600DF00D,
           RESP_OKAY, 3);
        wait_done();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
